// File: rtl/abuf_load_sched.sv
// abuf_load_sched: sequencer for the DDR-to-accum/bias buffer loader.
// One instruction at a time: conf, burst request, beat count, drain, done.
module abuf_load_sched #(
  parameter int PE_NUM     = 32,
  parameter int DDR_ADDR_W = 32,
  parameter int LEN_W      = 12,
  parameter int TAIL_SHIFT = 1,
  parameter int BIAS_SHIFT = 2,
  parameter int DRAIN_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [1:0]            ins_type,
  input  logic [7:0]            ins_num,
  input  logic [PE_NUM-1:0]     ins_mask,
  input  logic [DDR_ADDR_W-1:0] ins_addr,
  output logic                  ddr_req_valid,
  input  logic                  ddr_req_ready,
  output logic [DDR_ADDR_W-1:0] ddr_req_addr,
  output logic [LEN_W-1:0]      ddr_req_len,
  input  logic                  ddr_valid,
  output logic                  ddr_ready,
  output logic                  ld_start,
  output logic [1:0]            ld_trans_type,
  output logic [7:0]            ld_trans_num,
  output logic [PE_NUM-1:0]     ld_mask,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_REQ,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_type;
  logic [7:0]            r_num;
  logic [PE_NUM-1:0]     r_mask;
  logic [DDR_ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic [DW-1:0]         r_drain;
  logic [LEN_W-1:0]      w_beats;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_drain_end;

  assign w_accept    = (r_state == S_IDLE) && ins_valid;
  assign w_beat      = (r_state == S_STREAM) && ddr_valid;
  assign w_last      = w_beat && (r_cnt == LEN_W'(1));
  assign w_drain_end = (r_drain == DW'(DRAIN_CYC - 1));

  assign ld_trans_type = r_type;
  assign ld_trans_num  = r_num;
  assign ld_mask       = r_mask;
  assign ddr_req_addr  = r_addr;
  assign ddr_req_len   = r_len;

  // Burst length in beats from transfer type and entry count
  always_comb begin
    w_beats = LEN_W'(ins_num);
    unique case (ins_type)
      2'b01: w_beats = LEN_W'(ins_num) << TAIL_SHIFT;
      2'b10,
      2'b11: w_beats = (LEN_W'(ins_num)
                       + LEN_W'(2**BIAS_SHIFT - 1))
                       >> BIAS_SHIFT;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next        = r_state;
    ins_ready     = 1'b0;
    ld_start      = 1'b0;
    ddr_req_valid = 1'b0;
    ddr_ready     = 1'b0;
    done          = 1'b0;
    busy          = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        ins_ready = 1'b1;
        busy      = 1'b0;
        if (ins_valid)
          w_next = (ins_num == 8'd0) ? S_DONE : S_CONF;
      end
      S_CONF: begin
        ld_start = 1'b1;
        w_next   = S_REQ;
      end
      S_REQ: begin
        ddr_req_valid = 1'b1;
        if (ddr_req_ready) w_next = S_STREAM;
      end
      S_STREAM: begin
        ddr_ready = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_end) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Instruction latch; conf stays stable until next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type <= '0;
      r_num  <= '0;
      r_mask <= '0;
      r_addr <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_type <= ins_type;
      r_num  <= ins_num;
      r_mask <= ins_mask;
      r_addr <= ins_addr;
      r_len  <= w_beats;
    end
  end

  // Remaining beat counter, loaded on request handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == S_REQ && ddr_req_ready)
      r_cnt <= r_len;
    else if (w_beat)
      r_cnt <= r_cnt - LEN_W'(1);
  end

  // Drain cycle counter covering the loader write latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_drain <= '0;
    else if (r_state != S_DRAIN)
      r_drain <= '0;
    else
      r_drain <= r_drain + DW'(1);
  end

endmodule

// File: tb/tb_abuf_load_sched.sv
// tb_abuf_load_sched: randomized scoreboard bench for abuf_load_sched.
// Driver pushes expected responses; a negedge monitor pops and checks.
module tb_abuf_load_sched;

  localparam int PE = 32;
  localparam int AW = 32;
  localparam int LW = 12;
  localparam int TS = 1;
  localparam int BS = 2;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ins_valid;
  logic          ins_ready;
  logic [1:0]    ins_type;
  logic [7:0]    ins_num;
  logic [PE-1:0] ins_mask;
  logic [AW-1:0] ins_addr;
  logic          ddr_req_valid;
  logic          ddr_req_ready;
  logic [AW-1:0] ddr_req_addr;
  logic [LW-1:0] ddr_req_len;
  logic          ddr_valid;
  logic          ddr_ready;
  logic          ld_start;
  logic [1:0]    ld_trans_type;
  logic [7:0]    ld_trans_num;
  logic [PE-1:0] ld_mask;
  logic          busy;
  logic          done;

  abuf_load_sched #(
    .PE_NUM(PE), .DDR_ADDR_W(AW), .LEN_W(LW),
    .TAIL_SHIFT(TS), .BIAS_SHIFT(BS), .DRAIN_CYC(DC)
  ) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_type(ins_type), .ins_num(ins_num),
    .ins_mask(ins_mask), .ins_addr(ins_addr),
    .ddr_req_valid(ddr_req_valid),
    .ddr_req_ready(ddr_req_ready),
    .ddr_req_addr(ddr_req_addr),
    .ddr_req_len(ddr_req_len),
    .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .ld_start(ld_start),
    .ld_trans_type(ld_trans_type),
    .ld_trans_num(ld_trans_num),
    .ld_mask(ld_mask),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  num;
    logic [31:0] mask;
    logic [31:0] addr;
    int          len;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dv_pct  = 50;
  bit rnd_rdy = 1'b0;
  int hold_n  = 0;
  int ph      = 0;
  int mcnt    = 0;
  int mlast   = 0;
  int n_done  = 0;
  bit ld_seen = 1'b0;
  bit rq_seen = 1'b0;
  bit rq_first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Beat count straight from the transfer-type rules
  function automatic int ref_beats(input logic [1:0] t,
                                   input logic [7:0] n);
    int k;
    k = int'(n);
    case (t)
      2'b00:   return k;
      2'b01:   return k * (1 << TS);
      default: return (k + (1 << BS) - 1) / (1 << BS);
    endcase
  endfunction

  // DDR side: random data valid (also outside bursts) and req ready
  initial begin
    ddr_valid = 1'b0;
    ddr_req_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ddr_valid = ($urandom_range(99) < dv_pct);
      if (hold_n > 0) begin
        ddr_req_ready = 1'b0;
        if (ddr_req_valid) hold_n--;
      end else begin
        ddr_req_ready = rnd_rdy ? ($urandom_range(2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: compares DUT activity against the front of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      ph = 0; mcnt = 0;
      ld_seen = 0; rq_seen = 0; rq_first = 1;
    end else begin
      chk(ins_ready == !busy, "ins_ready_vs_busy", ins_ready, !busy);
      chk(ddr_ready == (ph == 1), "ddr_ready_gate",
          ddr_ready, (ph == 1));
      if (ld_start) begin
        if (exp_q.size() == 0) chk(0, "ld_start_unexpected", 1, 0);
        else begin
          me = exp_q[0];
          chk(me.num != 0 && !ld_seen, "ld_start_allowed",
              ld_seen, 0);
          chk(cyc == me.acc + 1, "ld_start_latency", cyc, me.acc + 1);
          chk(ld_trans_type == me.typ, "ld_type",
              ld_trans_type, me.typ);
          chk(ld_trans_num == me.num, "ld_num", ld_trans_num, me.num);
          chk(ld_mask == me.mask, "ld_mask", ld_mask, me.mask);
          ld_seen = 1;
        end
      end
      if (ddr_req_valid) begin
        if (exp_q.size() == 0) chk(0, "req_unexpected", 1, 0);
        else begin
          me = exp_q[0];
          if (rq_first) begin
            chk(me.num != 0, "req_for_nonzero", me.num, 1);
            chk(cyc == me.acc + 2, "req_latency", cyc, me.acc + 2);
            rq_first = 0;
          end
          chk(ddr_req_addr == me.addr, "req_addr",
              ddr_req_addr, me.addr);
          chk(int'(ddr_req_len) == me.len, "req_len",
              ddr_req_len, me.len);
          if (ddr_req_ready) begin
            chk(!rq_seen, "req_once", rq_seen, 0);
            rq_seen = 1; ph = 1; mcnt = 0;
          end
        end
      end
      if (ddr_valid && ddr_ready) begin
        chk(ph == 1, "beat_outside_stream", ph, 1);
        if (ph == 1 && exp_q.size() != 0) begin
          mcnt++;
          if (mcnt == exp_q[0].len) begin
            ph = 2; mlast = cyc;
          end
        end
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) chk(0, "done_unexpected", 1, 0);
        else begin
          me = exp_q.pop_front();
          if (me.num == 0) begin
            chk(cyc == me.acc + 1, "done_latency_zero",
                cyc, me.acc + 1);
            chk(!ld_seen && !rq_seen, "zero_no_traffic",
                ld_seen + rq_seen, 0);
          end else begin
            chk(ph == 2, "done_after_all_beats", mcnt, me.len);
            chk(cyc == mlast + DC + 1, "done_latency",
                cyc, mlast + DC + 1);
            chk(ld_trans_num == me.num && ld_mask == me.mask,
                "ld_conf_stable", ld_trans_num, me.num);
          end
        end
        ph = 0; mcnt = 0;
        ld_seen = 0; rq_seen = 0; rq_first = 1;
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic [7:0] n,
                       input logic [31:0] m, input logic [31:0] a);
    exp_t e;
    int w;
    bit ok;
    w = 0; ok = 0;
    @(posedge clk); #1;
    ins_valid = 1; ins_type = t; ins_num = n;
    ins_mask = m; ins_addr = a;
    while (!ok && w < 3000) begin
      @(negedge clk);
      if (ins_ready) ok = 1;
      else w++;
    end
    chk(ok, "accept_timeout", w, 0);
    if (ok) begin
      e.typ = t; e.num = n; e.mask = m; e.addr = a;
      e.len = ref_beats(t, n);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    ins_valid = 0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk(w < 5000, "complete_timeout", w, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(ins_ready == 1, {tag, "_ins_ready"}, ins_ready, 1);
    chk(busy == 0, {tag, "_busy"}, busy, 0);
    chk(done == 0, {tag, "_done"}, done, 0);
    chk(ld_start == 0, {tag, "_ld_start"}, ld_start, 0);
    chk(ddr_req_valid == 0, {tag, "_req_valid"}, ddr_req_valid, 0);
    chk(ddr_ready == 0, {tag, "_ddr_ready"}, ddr_ready, 0);
    chk(ddr_req_len == 0, {tag, "_req_len"}, ddr_req_len, 0);
    chk(ddr_req_addr == 0, {tag, "_req_addr"}, ddr_req_addr, 0);
    chk(ld_trans_type == 0, {tag, "_ld_type"}, ld_trans_type, 0);
    chk(ld_trans_num == 0, {tag, "_ld_num"}, ld_trans_num, 0);
    chk(ld_mask == 0, {tag, "_ld_mask"}, ld_mask, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int dd;
    logic [1:0] t;
    logic [7:0] n;
    rst = 1; ins_valid = 0; ins_type = 0; ins_num = 0;
    ins_mask = 0; ins_addr = 0;
    #3;
    chk_reset_outs("por");
    repeat (3) @(posedge clk);
    #1 rst = 0;

    dv_pct = 100;
    issue(2'b00, 8'd16, 32'h0000_00FF, 32'h1000);
    wait_idle();
    dv_pct = 50;
    issue(2'b01, 8'd10, 32'h0000_F0F0, 32'h2000);
    wait_idle();
    issue(2'b10, 8'd9, 32'h1234_5678, 32'h3000);
    wait_idle();
    issue(2'b11, 8'd8, 32'h8000_0001, 32'h4000);
    wait_idle();
    issue(2'b00, 8'd0, 32'hFFFF_FFFF, 32'h5000);
    wait_idle();
    issue(2'b11, 8'd1, 32'h0000_0003, 32'h5100);
    wait_idle();

    dv_pct = 100;
    hold_n = 7;
    issue(2'b00, 8'd4, 32'h0F0F_0F0F, 32'h6000);
    issue(2'b10, 8'd5, 32'hA5A5_A5A5, 32'h7000);
    wait_idle();
    issue(2'b01, 8'd255, 32'h0000_0001, 32'hFFFF_FFF0);
    wait_idle();

    rnd_rdy = 1;
    repeat (40) begin
      dv_pct = $urandom_range(20, 100);
      t = 2'($urandom_range(3));
      n = ($urandom_range(9) == 0) ? 8'd0
                                   : 8'($urandom_range(1, 60));
      issue(t, n, $urandom, $urandom);
      if ($urandom_range(1) == 1) wait_idle();
    end
    wait_idle();

    rnd_rdy = 0;
    dv_pct = 100;
    issue(2'b00, 8'd16, 32'h0000_00FF, 32'h1000);
    w = 0;
    while (!(ph == 1 && mcnt == 5) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk(w < 200, "reach_beat5_timeout", w, 0);
    #2 rst = 1;
    #1;
    chk_reset_outs("mid");
    exp_q.delete();
    dd = n_done;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (30) @(negedge clk);
    chk(n_done == dd, "no_done_after_reset", n_done, dd);
    chk(ins_ready == 1, "ready_after_reset", ins_ready, 1);

    dv_pct = 50;
    issue(2'b11, 8'd8, 32'h0000_1111, 32'h9000);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
